// File: rtl/jtframe_lock_cen.sv
// ============================================================================
//  Module   : jtframe_lock_cen
//  Purpose  : PLL-lock qualified game reset and phase-aligned 24/12/6/3 MHz
//             clock enables for the 48 MHz domain. Optional lock-loss counter
//             is enabled by defining JTFRAME_LOCKCNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jtframe_lock_cen #(
    parameter int HOLD = 4800,
    parameter int SYNC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       soft_rst,
    output logic       game_rst,
    output logic       ready,
    output logic       cen24,
    output logic       cen12,
    output logic       cen6,
    output logic       cen3,
    output logic [7:0] lost_cnt
);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    localparam logic [15:0] C_HOLD_LAST = 16'(HOLD - 1);

    logic [SYNC-1:0] r_sync;
    logic            w_lock_s;
    state_t          r_state;
    state_t          w_next;
    logic [15:0]     r_hcnt;
    logic [15:0]     w_hcnt_next;
    logic [3:0]      r_dcnt;
    logic            w_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC-2:0], pll_locked};
        end
    end

    assign w_lock_s = r_sync[SYNC-1];

    always_comb begin
        w_next      = r_state;
        w_hcnt_next = '0;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_lock_s) w_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (!w_lock_s) begin
                    w_next = ST_WAIT_LOCK;
                end else if (soft_rst) begin
                    w_hcnt_next = '0;
                end else if (r_hcnt == C_HOLD_LAST) begin
                    w_next = ST_RUN;
                end else begin
                    w_hcnt_next = r_hcnt + 16'd1;
                end
            end
            ST_RUN: begin
                // Losing lock wins over a pending host reset request
                if (!w_lock_s)     w_next = ST_WAIT_LOCK;
                else if (soft_rst) w_next = ST_HOLD;
            end
            default: w_next = ST_WAIT_LOCK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_WAIT_LOCK;
            r_hcnt   <= '0;
            r_dcnt   <= '0;
            game_rst <= 1'b1;
            ready    <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_hcnt   <= w_hcnt_next;
            // Divider restarts from zero on every entry into RUN
            r_dcnt   <= (r_state == ST_RUN && w_next == ST_RUN) ? r_dcnt + 4'd1 : 4'd0;
            game_rst <= (w_next != ST_RUN);
            ready    <= (w_next == ST_RUN);
        end
    end

    assign w_run = (r_state == ST_RUN);
    assign cen24 = w_run & r_dcnt[0];
    assign cen12 = w_run & (&r_dcnt[1:0]);
    assign cen6  = w_run & (&r_dcnt[2:0]);
    assign cen3  = w_run & (&r_dcnt);

`ifdef JTFRAME_LOCKCNT_EN
    logic [7:0] r_lost;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lost <= '0;
        end else if (r_state == ST_RUN && w_next == ST_WAIT_LOCK && r_lost != 8'hff) begin
            r_lost <= r_lost + 8'd1;
        end
    end

    assign lost_cnt = r_lost;
`else
    assign lost_cnt = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_jtframe_lock_cen.sv
// ============================================================================
//  Module   : tb_jtframe_lock_cen
//  Purpose  : Self-checking bench for jtframe_lock_cen: behavioural window
//             model compared every cycle, plus directed latency/ratio checks.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jtframe_lock_cen;

    localparam int HOLD = 8;
    localparam int SYNC = 2;
`ifdef JTFRAME_LOCKCNT_EN
    localparam bit LC_EN = 1'b1;
`else
    localparam bit LC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       soft_rst = 1'b0;
    logic       game_rst, ready, cen24, cen12, cen6, cen3;
    logic [7:0] lost_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    jtframe_lock_cen #(.HOLD(HOLD), .SYNC(SYNC)) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .soft_rst   (soft_rst),
        .game_rst   (game_rst),
        .ready      (ready),
        .cen24      (cen24),
        .cen12      (cen12),
        .cen6       (cen6),
        .cen3       (cen3),
        .lost_cnt   (lost_cnt)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: released once synced lock has held for HOLD+1 consecutive
    // samples and soft_rst has been quiet for the last HOLD samples.
    logic [SYNC-1:0] m_pipe = '0;
    int              m_lock_run = 0;
    int              m_soft_quiet = 0;
    bit              m_ready = 1'b0;
    int              m_run_len = 0;
    int              m_lost = 0;
    logic            m_ls;
    logic            m_ready_nx;

    assign m_ls       = m_pipe[SYNC-1];
    assign m_ready_nx = !rst && m_ls && !soft_rst &&
                        (m_lock_run >= HOLD) && (m_soft_quiet >= HOLD - 1);

    always @(posedge clk) begin
        m_pipe       <= rst ? '0 : {m_pipe[SYNC-2:0], pll_locked};
        m_lock_run   <= (rst || !m_ls) ? 0 : ((m_lock_run < 1000) ? m_lock_run + 1 : m_lock_run);
        m_soft_quiet <= (rst || soft_rst) ? 0 : ((m_soft_quiet < 1000) ? m_soft_quiet + 1 : m_soft_quiet);
        m_ready      <= m_ready_nx;
        m_run_len    <= m_ready_nx ? m_run_len + 1 : 0;
        if (rst)
            m_lost <= 0;
        else if (LC_EN && m_ready && !m_ls && m_lost < 255)
            m_lost <= m_lost + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int  dc;
        if (chk_en) begin
            dc = (m_run_len - 1) & 15;
            chk("m_game_rst", {31'd0, game_rst}, {31'd0, !m_ready});
            chk("m_ready",    {31'd0, ready},    {31'd0, m_ready});
            chk("m_cen24",    {31'd0, cen24},    {31'd0, m_ready && (dc % 2) == 1});
            chk("m_cen12",    {31'd0, cen12},    {31'd0, m_ready && (dc % 4) == 3});
            chk("m_cen6",     {31'd0, cen6},     {31'd0, m_ready && (dc % 8) == 7});
            chk("m_cen3",     {31'd0, cen3},     {31'd0, m_ready && dc == 15});
            chk("m_lost_cnt", {24'd0, lost_cnt}, m_lost);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input logic want, input int budget, input string tag);
        int n = 0;
        while (ready !== want && n < budget) begin
            step();
            n++;
        end
        if (ready !== want) begin
            checks++;
            errors++;
            $display("FAIL %s: timeout, ready=%b required %b", tag, ready, want);
        end
    endtask

    task automatic lose_once();
        pll_locked = 1'b1;
        wait_ready(1'b1, 100, "relock");
        repeat (3) step();
        pll_locked = 1'b0;
        wait_ready(1'b0, 20, "lockloss");
    endtask

    initial begin
        int t0, n24, n12, n6, n3, bad;
        bit seen;

        rst = 1'b1;
        step();
        step();
        chk_en = 1'b1;
        chk("rst_game_rst", {31'd0, game_rst}, 32'd1);
        chk("rst_ready",    {31'd0, ready},    32'd0);
        chk("rst_cens",     {28'd0, cen24, cen12, cen6, cen3}, 32'd0);
        chk("rst_lost",     {24'd0, lost_cnt}, 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_game_rst", {31'd0, game_rst}, 32'd1);

        // Clean lock: released SYNC+1+HOLD = 11 edges after the raise
        repeat (3) step();
        t0 = cyc;
        pll_locked = 1'b1;
        repeat (10) step();
        chk("lat_before_ready", {31'd0, ready},    32'd0);
        chk("lat_before_grst",  {31'd0, game_rst}, 32'd1);
        step();
        chk("lat_edge",         cyc - t0,          32'd11);
        chk("lat_ready",        {31'd0, ready},    32'd1);
        chk("lat_grst",         {31'd0, game_rst}, 32'd0);
        chk("lat_no_cen24",     {31'd0, cen24},    32'd0);
        step();
        chk("first_cen24",      {31'd0, cen24},    32'd1);

        // Enable ratios over 64 cycles
        n24 = 0; n12 = 0; n6 = 0; n3 = 0; bad = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            n24 += int'(cen24); n12 += int'(cen12); n6 += int'(cen6); n3 += int'(cen3);
            if ((cen3 && !cen6) || (cen6 && !cen12) || (cen12 && !cen24)) bad++;
        end
        chk("ratio_cen24", n24, 32'd32);
        chk("ratio_cen12", n12, 32'd16);
        chk("ratio_cen6",  n6,  32'd8);
        chk("ratio_cen3",  n3,  32'd4);
        chk("cen_nesting", bad, 32'd0);

        // Lock loss in RUN
        pll_locked = 1'b0;
        repeat (SYNC + 1) step();
        chk("loss_grst", {31'd0, game_rst}, 32'd1);
        chk("loss_cens", {28'd0, cen24, cen12, cen6, cen3}, 32'd0);
        chk("loss_lost", {24'd0, lost_cnt}, LC_EN ? 32'd1 : 32'd0);

        // Soft reset for 5 cycles in RUN
        pll_locked = 1'b1;
        wait_ready(1'b1, 100, "soft_relock");
        repeat (5) step();
        soft_rst = 1'b1;
        step();
        chk("soft_grst_next", {31'd0, game_rst}, 32'd1);
        repeat (4) step();
        soft_rst = 1'b0;
        repeat (HOLD - 1) step();
        chk("soft_before_release", {31'd0, ready}, 32'd0);
        step();
        chk("soft_release", {31'd0, ready}, 32'd1);
        chk("soft_no_cen24", {31'd0, cen24}, 32'd0);
        step();
        chk("soft_first_cen24", {31'd0, cen24}, 32'd1);

        // Glitch rejection: 6-cycle lock pulse
        pll_locked = 1'b0;
        wait_ready(1'b0, 20, "glitch_drop");
        repeat (4) step();
        seen = 1'b0;
        pll_locked = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if (i == 6) pll_locked = 1'b0;
            step();
            seen |= ready | cen24 | cen12 | cen6 | cen3 | !game_rst;
        end
        chk("glitch_reject", {31'd0, seen}, 32'd0);

        // Mid-operation reset with three prior losses
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) lose_once();
        chk("three_losses", {24'd0, lost_cnt}, LC_EN ? 32'd3 : 32'd0);
        pll_locked = 1'b1;
        wait_ready(1'b1, 100, "pre_rst_lock");
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_lost", {24'd0, lost_cnt}, 32'd0);
        chk("midrst_grst", {31'd0, game_rst}, 32'd1);
        repeat (10) step();
        chk("midrst_before", {31'd0, ready}, 32'd0);
        step();
        chk("midrst_release", {31'd0, ready}, 32'd1);

        // Saturation after 256 losses
        for (int i = 0; i < 256; i++) lose_once();
        chk("lost_saturate", {24'd0, lost_cnt}, LC_EN ? 32'd255 : 32'd0);

        // Randomized phase, checked against the model each cycle
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) pll_locked = !pll_locked;
            soft_rst = ($urandom_range(0, 99) < 3);
            rst      = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        soft_rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
